// File: rtl/out_bus_sequencer.sv
// Registered output-bus multiplexer: manual channel select or timed auto-scan, with hold/freeze.
// Auto-scan (SCAN state, dwell counter, MODE handling) is built only when OUT_BUS_SEQUENCER_SCAN_EN is defined.
module out_bus_sequencer #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 5,
   parameter int SEL_W    = 3,
   parameter int DWELL    = 16
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
   input  logic [SEL_W-1:0]          SELECT,
   input  logic                      MODE,
   input  logic                      HOLD,
   output logic [WIDTH-1:0]          OUT_DATA,
   output logic [SEL_W-1:0]          OUT_CH,
   output logic                      OUT_VALID,
   output logic                      OUT_CHANGE
);

   localparam int             NUM_SLOTS = 2 ** SEL_W;
   localparam logic [SEL_W:0] CH_LIM    = (SEL_W + 1)'(CHANNELS);

   logic [WIDTH-1:0] chan [NUM_SLOTS];
   logic [SEL_W-1:0] idx_nxt;
   logic [WIDTH-1:0] data_nxt;
   logic             valid_nxt;
   logic             change_nxt;

   // Unused index slots read as zero, so an out-of-range index needs no extra masking.
   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_chan
      if (g < CHANNELS) begin : g_used
         assign chan[g] = IN_DATA[g*WIDTH +: WIDTH];
      end else begin : g_pad
         assign chan[g] = '0;
      end
   end

`ifdef OUT_BUS_SEQUENCER_SCAN_EN
   localparam int               CNT_W    = $clog2(DWELL) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(CHANNELS - 1);

   typedef enum logic {ST_MANUAL, ST_SCAN} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
`else
   logic unused_mode;
   assign unused_mode = MODE;
`endif

   // NOTE: every output of this block gets a default first so no path leaves a latch behind.
   always_comb begin
      idx_nxt    = OUT_CH;
      data_nxt   = OUT_DATA;
      valid_nxt  = OUT_VALID;
      change_nxt = 1'b0;
`ifdef OUT_BUS_SEQUENCER_SCAN_EN
      state_nxt  = state;
      cnt_nxt    = cnt;
`endif
      if (!HOLD) begin
`ifdef OUT_BUS_SEQUENCER_SCAN_EN
         case (state)
            ST_MANUAL: begin
               if (MODE) begin
                  state_nxt = ST_SCAN;
                  idx_nxt   = '0;
                  cnt_nxt   = '0;
               end else begin
                  idx_nxt = SELECT;
               end
            end
            ST_SCAN: begin
               if (!MODE) begin
                  state_nxt = ST_MANUAL;
                  cnt_nxt   = '0;
                  idx_nxt   = SELECT;
               end else if (cnt == CNT_LAST) begin
                  cnt_nxt = '0;
                  idx_nxt = (OUT_CH == IDX_LAST) ? '0 : OUT_CH + SEL_W'(1);
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            default: state_nxt = ST_MANUAL;
         endcase
`else
         idx_nxt = SELECT;
`endif
         // Data follows the live channel value on every non-held edge, in both modes.
         data_nxt   = chan[idx_nxt];
         valid_nxt  = ({1'b0, idx_nxt} < CH_LIM);
         change_nxt = (idx_nxt != OUT_CH);
      end
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         OUT_DATA   <= '0;
         OUT_CH     <= '0;
         OUT_VALID  <= 1'b0;
         OUT_CHANGE <= 1'b0;
`ifdef OUT_BUS_SEQUENCER_SCAN_EN
         state      <= ST_MANUAL;
         cnt        <= '0;
`endif
      end else begin
         OUT_DATA   <= data_nxt;
         OUT_CH     <= idx_nxt;
         OUT_VALID  <= valid_nxt;
         OUT_CHANGE <= change_nxt;
`ifdef OUT_BUS_SEQUENCER_SCAN_EN
         state      <= state_nxt;
         cnt        <= cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_out_bus_sequencer.sv
// Randomized self-checking bench for out_bus_sequencer against a cycle-count reference model.
// Scan expectations apply only when OUT_BUS_SEQUENCER_SCAN_EN is defined for the build.
module tb_out_bus_sequencer;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 5;
   localparam int SEL_W    = 3;
   localparam int DWELL    = 4;

`ifdef OUT_BUS_SEQUENCER_SCAN_EN
   localparam bit SCAN_EN = 1'b1;
`else
   localparam bit SCAN_EN = 1'b0;
`endif

   logic                      clk = 1'b0;
   logic                      rst;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]          select;
   logic                      mode;
   logic                      hold;
   logic [WIDTH-1:0]          out_data;
   logic [SEL_W-1:0]          out_ch;
   logic                      out_valid;
   logic                      out_change;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int exp_data, exp_ch, exp_valid, exp_change;
   bit m_scan;
   int ticks;

   out_bus_sequencer #(
      .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .DWELL(DWELL)
   ) dut (
      .CLK(clk), .RST(rst), .IN_DATA(in_data), .SELECT(select), .MODE(mode), .HOLD(hold),
      .OUT_DATA(out_data), .OUT_CH(out_ch), .OUT_VALID(out_valid), .OUT_CHANGE(out_change)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int chan_val(input int ch);
      return (ch < CHANNELS) ? int'(in_data[ch*WIDTH +: WIDTH]) : 0;
   endfunction

   // Scan position is derived from the number of non-held scan edges since entry.
   task automatic model_edge();
      int prev, nch;
      if (rst) begin
         exp_data = 0; exp_ch = 0; exp_valid = 0; exp_change = 0;
         m_scan = 1'b0; ticks = 0;
      end else if (hold) begin
         exp_change = 0;
      end else begin
         prev = exp_ch;
         if (SCAN_EN && mode) begin
            if (!m_scan) begin
               m_scan = 1'b1;
               ticks  = 0;
            end else begin
               ticks++;
            end
            nch = (ticks / DWELL) % CHANNELS;
         end else begin
            m_scan = 1'b0;
            nch    = int'(select);
         end
         exp_ch     = nch;
         exp_valid  = (nch < CHANNELS) ? 1 : 0;
         exp_data   = chan_val(nch);
         exp_change = (nch != prev) ? 1 : 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("out_data",   32'(out_data),   exp_data);
      check("out_ch",     32'(out_ch),     exp_ch);
      check("out_valid",  32'(out_valid),  exp_valid);
      check("out_change", 32'(out_change), exp_change);
   endtask

   initial begin
      rst     = 1'b1;
      hold    = 1'b0;
      mode    = 1'b0;
      select  = 3'($urandom_range(0, 7));
      in_data = {8'($urandom), 32'($urandom)};
      exp_data = 0; exp_ch = 0; exp_valid = 0; exp_change = 0;
      m_scan = 1'b0; ticks = 0;

      // Reset held for two cycles with arbitrary inputs
      repeat (2) step();
      rst = 1'b0;

      // Manual select, including an out-of-range index
      in_data = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      select  = 3'd3; step();
      select  = 3'd1; step();
      select  = 3'd6; step();
      select  = 3'd7; hold = 1'b1; step();
      hold    = 1'b0; select = 3'd0; step();

      // Scan rotation through a full wrap, with a live update on channel 2 mid-dwell
      mode = 1'b1;
      for (int n = 0; n < 2 * CHANNELS * DWELL + 2; n++) begin
         if (n == 9) in_data[2*WIDTH +: WIDTH] = 8'hA5;
         select = 3'($urandom_range(0, 7));
         step();
      end

      // Hold for three cycles early in a dwell while toggling MODE/SELECT
      mode = 1'b0; step();
      mode = 1'b1;
      repeat (DWELL + 1) step();
      for (int n = 0; n < 3; n++) begin
         hold   = 1'b1;
         mode   = ~mode;
         select = 3'($urandom_range(0, 7));
         step();
      end
      hold = 1'b0; mode = 1'b1;
      repeat (DWELL + 2) step();

      // Manual again: MODE low, then MODE high is either scan entry or ignored
      mode = 1'b0; select = 3'd2; step();
      mode = 1'b1;
      repeat (6) step();

      // Randomized mix of all inputs
      for (int n = 0; n < 600; n++) begin
         rst  = ($urandom_range(0, 99) == 0);
         hold = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 29) == 0) mode = ~mode;
         select = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0)
            in_data[$urandom_range(0, CHANNELS - 1)*WIDTH +: WIDTH] = 8'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
